// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address, one write or read byte, ACK/NACK, STOP.
// Each bus bit is 4 phases of QTR clocks, stretched by the slave; done pulses one cycle after STOP.
module i2c_master_ctrl #(
    parameter int QTR = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [6:0] addr_i,
    input  logic       rw_i,
    input  logic [7:0] wdata_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic [7:0] rdata
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_START    = 4'd1;
    localparam logic [3:0] S_ADDR     = 4'd2;
    localparam logic [3:0] S_ADDR_ACK = 4'd3;
    localparam logic [3:0] S_WRITE    = 4'd4;
    localparam logic [3:0] S_WR_ACK   = 4'd5;
    localparam logic [3:0] S_READ     = 4'd6;
    localparam logic [3:0] S_RD_NACK  = 4'd7;
    localparam logic [3:0] S_STOP     = 4'd8;
    localparam logic [3:0] S_DONE     = 4'd9;

    localparam logic [9:0] QTR_M1 = 10'(QTR - 1);

    logic [3:0] state;
    logic [1:0] phase;
    logic [9:0] cnt;
    logic [2:0] bit_cnt;
    logic [6:0] addr_q;
    logic       rw_q;
    logic [7:0] wdata_q;
    logic [7:0] rx_sh;
    logic       sda_smp;

    logic scl_meta, scl_s, sda_meta, sda_s;
    logic rel_d1, rel_d2;

    logic       idle_like, accept, last_qtr, hold, samp_now, bit_end, tx_bit;
    logic [7:0] addr_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_meta <= 1'b1;
            scl_s    <= 1'b1;
            sda_meta <= 1'b1;
            sda_s    <= 1'b1;
            rel_d1   <= 1'b1;
            rel_d2   <= 1'b1;
        end else begin
            scl_meta <= scl_i;
            scl_s    <= scl_meta;
            sda_meta <= sda_i;
            sda_s    <= sda_meta;
            rel_d1   <= ~scl_oe;
            rel_d2   <= rel_d1;
        end
    end

    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    assign accept    = idle_like && start_i;
    assign last_qtr  = (cnt == QTR_M1);
    // rel_d2 is aligned with scl_s, so a low SCL only counts as a stretch
    // once our own release has had time to reach the synchronizer output.
    assign hold      = !idle_like && phase[1] && rel_d2 && !scl_s;
    assign samp_now  = (phase == 2'd2) && last_qtr && !hold;
    assign bit_end   = (phase == 2'd3) && last_qtr && !hold;

    assign addr_byte = {addr_q, rw_q};
    assign tx_bit    = (state == S_WRITE) ? wdata_q[3'd7 - bit_cnt] : addr_byte[3'd7 - bit_cnt];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            phase   <= 2'd0;
            cnt     <= 10'd0;
            bit_cnt <= 3'd0;
            addr_q  <= 7'd0;
            rw_q    <= 1'b0;
            wdata_q <= 8'd0;
            rx_sh   <= 8'd0;
            sda_smp <= 1'b1;
            nack    <= 1'b0;
            rdata   <= 8'd0;
        end else if (accept) begin
            addr_q  <= addr_i;
            rw_q    <= rw_i;
            wdata_q <= wdata_i;
            nack    <= 1'b0;
            state   <= S_START;
            phase   <= 2'd0;
            cnt     <= 10'd0;
            bit_cnt <= 3'd0;
        end else if (state == S_DONE) begin
            state <= S_IDLE;
        end else if (state != S_IDLE) begin
            if (hold) begin
                phase <= 2'd2;
                cnt   <= 10'd0;
            end else if (last_qtr) begin
                cnt   <= 10'd0;
                phase <= phase + 2'd1;
            end else begin
                cnt <= cnt + 10'd1;
            end

            if (samp_now) begin
                sda_smp <= sda_s;
                if (state == S_READ)
                    rx_sh <= {rx_sh[6:0], sda_s};
            end

            if (bit_end) begin
                case (state)
                    S_START: begin
                        state   <= S_ADDR;
                        bit_cnt <= 3'd0;
                    end
                    S_ADDR: begin
                        if (bit_cnt == 3'd7) state <= S_ADDR_ACK;
                        else                 bit_cnt <= bit_cnt + 3'd1;
                    end
                    S_ADDR_ACK: begin
                        bit_cnt <= 3'd0;
                        if (sda_smp) begin
                            nack  <= 1'b1;
                            state <= S_STOP;
                        end else if (rw_q) begin
                            state <= S_READ;
                        end else begin
                            state <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        if (bit_cnt == 3'd7) state <= S_WR_ACK;
                        else                 bit_cnt <= bit_cnt + 3'd1;
                    end
                    S_WR_ACK: begin
                        if (sda_smp) nack <= 1'b1;
                        state <= S_STOP;
                    end
                    S_READ: begin
                        if (bit_cnt == 3'd7) state <= S_RD_NACK;
                        else                 bit_cnt <= bit_cnt + 3'd1;
                    end
                    S_RD_NACK: state <= S_STOP;
                    S_STOP: begin
                        state <= S_DONE;
                        if (rw_q && !nack) rdata <= rx_sh;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Pad enables decode straight from state so reset releases the bus immediately.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state)
            S_START: sda_oe = phase[1];
            S_ADDR, S_WRITE: begin
                scl_oe = ~phase[1];
                sda_oe = ~tx_bit;
            end
            S_ADDR_ACK, S_WR_ACK, S_READ, S_RD_NACK: scl_oe = ~phase[1];
            S_STOP: begin
                scl_oe = (phase == 2'd0);
                sda_oe = ~phase[1];
            end
            default: ;
        endcase
    end

    assign busy = !idle_like;
    assign done = (state == S_DONE);

endmodule
